mac_acc_sched: RTL

- Sequencing controller for the bit-serial DCIM MAC path.
- Accepts a job (input bit-width, weight width, signedness) and issues input-bit indices MSB-first to the macro array.
- Collects each 27-bit combined partial sum from global_io after a fixed array latency and shift-accumulates it into a 51-bit result.
- Returns the result over a valid/ready handshake. Sits between the top-level job interface and the array + global_io datapath, and drives global_io's wwidth.

---
 rtl/mac_acc_pkg.sv | 19 +
 rtl/mac_tag_pipe.sv | 53 +++++
 rtl/mac_acc_sched.sv | 115 +++++++++++
 3 files changed

// File: rtl/mac_acc_pkg.sv
// Shared types and constants for the bit-serial MAC sequencing controller.
package mac_acc_pkg;

  localparam int PS_W    = 27;
  localparam int ACC_W   = 51;
  localparam int IBW_MAX = 16;
  localparam int IDX_W   = $clog2(IBW_MAX);
  localparam int CFG_W   = 5;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  // Requested input width mapped onto 1..IBW_MAX.
  function automatic logic [CFG_W-1:0] clamp_ibits(input logic [CFG_W-1:0] ibits);
    if (ibits == '0) return CFG_W'(1);
    if (ibits > CFG_W'(IBW_MAX)) return CFG_W'(IBW_MAX);
    return ibits;
  endfunction

endpackage

// File: rtl/mac_tag_pipe.sv
// LAT-deep {valid, first} shift register that tracks issued bits through the
// array latency so the partial sum can be matched to its bit position.
module mac_tag_pipe #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic push_vld,
  input  logic push_first,
  output logic out_vld,
  output logic out_first,
  output logic pend
);

  // Every stage except the output one; used to decide when draining is done.
  localparam logic [LAT-1:0] PEND_MASK = {LAT{1'b1}} >> 1;

  logic [LAT-1:0] vld_q, vld_d;
  logic [LAT-1:0] first_q, first_d;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    vld_d      = '0;
    first_d    = '0;
    vld_d[0]   = push_vld;
    first_d[0] = push_first;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i]   = vld_q[i-1];
      first_d[i] = first_q[i-1];
    end
    if (clr) begin
      vld_d   = '0;
      first_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      vld_q   <= '0;
      first_q <= '0;
    end else begin
      vld_q   <= vld_d;
      first_q <= first_d;
    end
  end

  assign out_vld   = vld_q[LAT-1];
  assign out_first = first_q[LAT-1];
  assign pend      = |(vld_q & PEND_MASK);

endmodule

// File: rtl/mac_acc_sched.sv
// Job sequencer for the bit-serial DCIM MAC path: issues input bits MSB-first,
// shift-accumulates the returning partial sums and hands back the result.
module mac_acc_sched
  import mac_acc_pkg::*;
#(
  parameter int MAC_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [CFG_W-1:0]   cfg_ibits,
  input  logic               cfg_wwidth,
  input  logic               cfg_signed,
  output logic               busy,
  output logic               bit_vld,
  output logic [IDX_W-1:0]   bit_idx,
  output logic               wwidth,
  input  logic [PS_W-1:0]    ps_in,
  output logic [ACC_W-1:0]   res,
  output logic               res_vld,
  input  logic               res_rdy
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               signed_q, signed_d;
  logic               wwidth_q, wwidth_d;
  logic               first_q, first_d;

  logic               pipe_vld, pipe_first, pipe_pend;
  logic               issuing;
  logic [ACC_W-1:0]   ps_ext, term;

  assign issuing = (state_q == ISSUE);

  mac_tag_pipe #(.LAT(MAC_LAT)) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .clr        (abort),
    .push_vld   (issuing),
    .push_first (issuing & first_q),
    .out_vld    (pipe_vld),
    .out_first  (pipe_first),
    .pend       (pipe_pend)
  );

  // The MSB of a two's-complement input carries negative weight.
  assign ps_ext = {{(ACC_W-PS_W){ps_in[PS_W-1]}}, ps_in};
  assign term   = (pipe_first && signed_q) ? -ps_ext : ps_ext;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    signed_d = signed_q;
    wwidth_d = wwidth_q;
    first_d  = first_q;

    if (pipe_vld) acc_d = (acc_q << 1) + term;

    case (state_q)
      IDLE: if (start) begin
        state_d  = ISSUE;
        cnt_d    = IDX_W'(clamp_ibits(cfg_ibits) - CFG_W'(1));
        acc_d    = '0;
        signed_d = cfg_signed;
        wwidth_d = cfg_wwidth;
        first_d  = 1'b1;
      end
      ISSUE: begin
        first_d = 1'b0;
        if (cnt_q == '0) state_d = DRAIN;
        else             cnt_d   = cnt_q - IDX_W'(1);
      end
      // Leave once the entry now at the output is the last one in flight.
      DRAIN: if (!pipe_pend) state_d = DONE;
      DONE:  if (res_rdy)    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      acc_d   = '0;
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      signed_q <= 1'b0;
      wwidth_q <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      signed_q <= signed_d;
      wwidth_q <= wwidth_d;
      first_q  <= first_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign bit_vld = issuing;
  assign bit_idx = issuing ? cnt_q : '0;
  assign wwidth  = wwidth_q;
  assign res     = acc_q;
  assign res_vld = (state_q == DONE);

endmodule
